// File: rtl/apa102_pkg.sv
// Shared types and framing constants for the APA102 serial receiver.
package apa102_pkg;

   typedef enum logic [1:0] {
      HUNT,
      HEADER,
      PAYLOAD,
      END
   } state_e;

   localparam int START_FRAME_BITS = 32;
   localparam int END_FRAME_BITS   = 32;
   localparam int HEADER_BITS      = 8;
   localparam int PIXEL_BITS       = 24;
   localparam int WORD_BITS        = 16;

   localparam logic [2:0] HEADER_MARKER = 3'b111;

   // Moves the n valid LSBs of a partial word to the top, zero-filling below.
   function automatic logic [15:0] left_align(input logic [15:0] bits, input logic [3:0] n);
      return bits << (5'd16 - {1'b0, n});
   endfunction

endpackage

// File: rtl/apa102_in_input_sync_edge.sv
// Two-flop synchroniser for one asynchronous line plus rising-edge detect.
module input_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], async_in};
      prev_d = sync_q[1];
   end

   // NOTE: sequential state is always written with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q[1];
   assign rise     = sync_q[1] & ~prev_q;

endmodule

// File: rtl/apa102_in.sv
// APA102 stream receiver: unpacks BGR payload into 16-bit page-memory writes.
// Optional header marker check: define APA102_IN_HEADER_CHECK_EN.
module apa102_in
   import apa102_pkg::*;
#(
   parameter int ADDRESS_BUS_WIDTH = 16,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         apa_clock_in,
   input  logic                         apa_data_in,
   input  logic [15:0]                  led_count,
   input  logic [15:0]                  start_address,
   output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
   output logic [15:0]                  write_data,
   output logic                         write_strobe,
   output logic                         frame_done_strobe,
   output logic                         header_error,
   output logic                         busy
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic clk_rise, data_bit;
   logic clk_sync_unused, data_rise_unused;

   input_sync_edge u_clk_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (apa_clock_in),
      .sync_out (clk_sync_unused),
      .rise     (clk_rise)
   );

   input_sync_edge u_data_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (apa_data_in),
      .sync_out (data_bit),
      .rise     (data_rise_unused)
   );

   state_e                       state_q, state_d;
   logic [4:0]                   bit_cnt_q, bit_cnt_d;
   logic [15:0]                  leds_left_q, leds_left_d;
   logic [ADDRESS_BUS_WIDTH-1:0] word_ptr_q, word_ptr_d;
   logic [15:0]                  shift_q, shift_d;
   logic [3:0]                   pack_cnt_q, pack_cnt_d;
   logic                         arm_q, arm_d;
   logic [TMO_W-1:0]             tmo_q, tmo_d;
   logic [ADDRESS_BUS_WIDTH-1:0] write_address_q, write_address_d;
   logic [15:0]                  write_data_q, write_data_d;
   logic                         write_strobe_q, write_strobe_d;
   logic                         frame_done_q, frame_done_d;
   logic [15:0]                  word;
`ifdef APA102_IN_HEADER_CHECK_EN
   logic [7:0]                   hdr_q, hdr_d;
   logic                         header_error_q, header_error_d;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      leds_left_d     = leds_left_q;
      word_ptr_d      = word_ptr_q;
      shift_d         = shift_q;
      pack_cnt_d      = pack_cnt_q;
      arm_d           = arm_q;
      tmo_d           = '0;
      write_address_d = write_address_q;
      write_data_d    = write_data_q;
      write_strobe_d  = 1'b0;
      frame_done_d    = 1'b0;
      word            = {shift_q[14:0], data_bit};
`ifdef APA102_IN_HEADER_CHECK_EN
      hdr_d           = hdr_q;
      header_error_d  = header_error_q;
`endif

      if (state_q != HUNT && !clk_rise) tmo_d = tmo_q + TMO_W'(1);

      if (clk_rise) begin
         case (state_q)
            HUNT: begin
               if (data_bit) begin
                  bit_cnt_d = '0;
               end else if (bit_cnt_q == 5'(START_FRAME_BITS - 1)) begin
                  bit_cnt_d   = '0;
                  leds_left_d = led_count;
                  word_ptr_d  = ADDRESS_BUS_WIDTH'(start_address);
                  shift_d     = '0;
                  pack_cnt_d  = '0;
                  arm_d       = 1'b1;
                  state_d     = (led_count == 16'd0) ? END : HEADER;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end

            HEADER: begin
               // Zeros after a completed start frame are padding until the first 1.
               if (!(arm_q && !data_bit)) begin
                  arm_d     = 1'b0;
                  bit_cnt_d = bit_cnt_q + 5'd1;
`ifdef APA102_IN_HEADER_CHECK_EN
                  hdr_d     = {hdr_q[6:0], data_bit};
`endif
                  if (bit_cnt_q == 5'(HEADER_BITS - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = PAYLOAD;
`ifdef APA102_IN_HEADER_CHECK_EN
                     if (hdr_q[6:4] != HEADER_MARKER) begin
                        header_error_d = 1'b1;
                        shift_d        = '0;
                        pack_cnt_d     = '0;
                        state_d        = HUNT;
                     end
`endif
                  end
               end
            end

            PAYLOAD: begin
               if (pack_cnt_q == 4'(WORD_BITS - 1)) begin
                  write_strobe_d  = 1'b1;
                  write_data_d    = word;
                  write_address_d = word_ptr_q;
                  word_ptr_d      = word_ptr_q + ADDRESS_BUS_WIDTH'(1);
                  shift_d         = '0;
                  pack_cnt_d      = '0;
               end else begin
                  shift_d    = word;
                  pack_cnt_d = pack_cnt_q + 4'd1;
               end
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(PIXEL_BITS - 1)) begin
                  bit_cnt_d   = '0;
                  leds_left_d = leds_left_q - 16'd1;
                  if (leds_left_q != 16'd1) begin
                     state_d = HEADER;
                  end else begin
                     state_d = END;
                     // A partial word and a full-word emit can never coincide.
                     if (pack_cnt_d != 4'd0) begin
                        write_strobe_d  = 1'b1;
                        write_data_d    = left_align(shift_d, pack_cnt_d);
                        write_address_d = word_ptr_q;
                        word_ptr_d      = word_ptr_q + ADDRESS_BUS_WIDTH'(1);
                        shift_d         = '0;
                        pack_cnt_d      = '0;
                     end
                  end
               end
            end

            END: begin
               if (!data_bit) begin
                  bit_cnt_d = '0;
               end else if (bit_cnt_q == 5'(END_FRAME_BITS - 1)) begin
                  bit_cnt_d    = '0;
                  frame_done_d = 1'b1;
                  state_d      = HUNT;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end

            default: state_d = HUNT;
         endcase
      end else if (state_q != HUNT && tmo_q == TMO_LAST) begin
         state_d    = HUNT;
         bit_cnt_d  = '0;
         shift_d    = '0;
         pack_cnt_d = '0;
         tmo_d      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= HUNT;
         bit_cnt_q       <= '0;
         leds_left_q     <= '0;
         word_ptr_q      <= '0;
         shift_q         <= '0;
         pack_cnt_q      <= '0;
         arm_q           <= 1'b0;
         tmo_q           <= '0;
         write_address_q <= '0;
         write_data_q    <= '0;
         write_strobe_q  <= 1'b0;
         frame_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         leds_left_q     <= leds_left_d;
         word_ptr_q      <= word_ptr_d;
         shift_q         <= shift_d;
         pack_cnt_q      <= pack_cnt_d;
         arm_q           <= arm_d;
         tmo_q           <= tmo_d;
         write_address_q <= write_address_d;
         write_data_q    <= write_data_d;
         write_strobe_q  <= write_strobe_d;
         frame_done_q    <= frame_done_d;
      end
   end

`ifdef APA102_IN_HEADER_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_q          <= '0;
         header_error_q <= 1'b0;
      end else begin
         hdr_q          <= hdr_d;
         header_error_q <= header_error_d;
      end
   end

   assign header_error = header_error_q;
`else
   assign header_error = 1'b0;
`endif

   assign write_address     = write_address_q;
   assign write_data        = write_data_q;
   assign write_strobe      = write_strobe_q;
   assign frame_done_strobe = frame_done_q;
   assign busy              = (state_q != HUNT);

endmodule

// File: tb/tb_apa102_in.sv
// Directed bench for apa102_in: serial frames in, captured memory writes checked.
module tb_apa102_in;

   localparam int TMO = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        apa_clock_in;
   logic        apa_data_in;
   logic [15:0] led_count;
   logic [15:0] start_address;
   logic [15:0] write_address;
   logic [15:0] write_data;
   logic        write_strobe;
   logic        frame_done_strobe;
   logic        header_error;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] wa_q[$];
   logic [15:0] wd_q[$];
   int          done_cnt      = 0;
   int          double_strobe = 0;
   logic        prev_strobe   = 1'b0;

   apa102_in #(
      .ADDRESS_BUS_WIDTH (16),
      .TIMEOUT_CYCLES    (TMO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .apa_clock_in      (apa_clock_in),
      .apa_data_in       (apa_data_in),
      .led_count         (led_count),
      .start_address     (start_address),
      .write_address     (write_address),
      .write_data        (write_data),
      .write_strobe      (write_strobe),
      .frame_done_strobe (frame_done_strobe),
      .header_error      (header_error),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_strobe) begin
         wa_q.push_back(write_address);
         wd_q.push_back(write_data);
         if (prev_strobe) double_strobe++;
      end
      if (frame_done_strobe) done_cnt++;
      prev_strobe = write_strobe;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_write(input string tag, input int i, input logic [15:0] a, input logic [15:0] d);
      logic [31:0] oa, od;
      oa = (i < wa_q.size()) ? {16'h0, wa_q[i]} : 32'hFFFF_FFFF;
      od = (i < wd_q.size()) ? {16'h0, wd_q[i]} : 32'hFFFF_FFFF;
      check({tag, "_addr"}, oa, {16'h0, a});
      check({tag, "_data"}, od, {16'h0, d});
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      apa_data_in  = b;
      apa_clock_in = 1'b0;
      repeat (4) @(posedge clk);
      apa_clock_in = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_start();
      send_bits(32'h0, 32);
   endtask

   task automatic send_led(input logic [7:0] hdr, input logic [23:0] pix);
      send_bits({24'h0, hdr}, 8);
      send_bits({8'h0, pix}, 24);
   endtask

   task automatic send_end();
      send_bits(32'hFFFF_FFFF, 32);
      repeat (10) @(posedge clk);
   endtask

   initial begin
      logic found;
      rst           = 1'b1;
      apa_clock_in  = 1'b0;
      apa_data_in   = 1'b0;
      led_count     = 16'd0;
      start_address = 16'h0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_write_strobe", {31'h0, write_strobe}, 32'h0);
      check("rst_write_data", {16'h0, write_data}, 32'h0);
      check("rst_write_address", {16'h0, write_address}, 32'h0);
      check("rst_frame_done", {31'h0, frame_done_strobe}, 32'h0);
      check("rst_header_error", {31'h0, header_error}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);

      // Two LEDs, exact word fit
      clear_log();
      led_count = 16'd2; start_address = 16'h0100;
      send_start();
      check("t1_busy_after_start", {31'h0, busy}, 32'h1);
      send_led(8'hFF, 24'h123456);
      send_led(8'hFF, 24'h789ABC);
      send_end();
      check("t1_nwrites", wa_q.size(), 32'd3);
      check_write("t1_w0", 0, 16'h0100, 16'h1234);
      check_write("t1_w1", 1, 16'h0101, 16'h5678);
      check_write("t1_w2", 2, 16'h0102, 16'h9ABC);
      check("t1_done", done_cnt, 32'd1);
      check("t1_busy_idle", {31'h0, busy}, 32'h0);

      // One LED, partial word flushed left-aligned
      clear_log();
      led_count = 16'd1; start_address = 16'h0100;
      send_start();
      send_led(8'hFF, 24'hA5C33C);
      send_end();
      check("t2_nwrites", wa_q.size(), 32'd2);
      check_write("t2_w0", 0, 16'h0100, 16'hA5C3);
      check_write("t2_flush", 1, 16'h0101, 16'h3C00);
      check("t2_done", done_cnt, 32'd1);

      // Bad marker on the second header
      clear_log();
      led_count = 16'd2; start_address = 16'h0100;
      send_start();
      send_led(8'hFF, 24'h123456);
      send_led(8'h5F, 24'h0F0F0F);
      send_end();
`ifdef APA102_IN_HEADER_CHECK_EN
      check("t3_nwrites", wa_q.size(), 32'd1);
      check_write("t3_w0", 0, 16'h0100, 16'h1234);
      check("t3_done", done_cnt, 32'd0);
      check("t3_header_error", {31'h0, header_error}, 32'h1);
`else
      check("t3_nwrites", wa_q.size(), 32'd3);
      check_write("t3_w0", 0, 16'h0100, 16'h1234);
      check_write("t3_w1", 1, 16'h0101, 16'h560F);
      check_write("t3_w2", 2, 16'h0102, 16'h0F0F);
      check("t3_done", done_cnt, 32'd1);
      check("t3_header_error", {31'h0, header_error}, 32'h0);
`endif

      // Serial clock stalls mid-payload
      clear_log();
      led_count = 16'd1; start_address = 16'h0200;
      send_start();
      send_bits(32'hFF, 8);
      send_bits(32'h2AB, 10);
      check("t4_busy_before_stall", {31'h0, busy}, 32'h1);
      apa_clock_in = 1'b0;
      repeat (TMO + 1) @(posedge clk);
      @(negedge clk);
      check("t4_busy_after_timeout", {31'h0, busy}, 32'h0);
      check("t4_no_write_aborted", wa_q.size(), 32'd0);
      send_start();
      send_led(8'hFF, 24'hA5C33C);
      send_end();
      check("t4_nwrites", wa_q.size(), 32'd2);
      check_write("t4_w0", 0, 16'h0200, 16'hA5C3);
      check_write("t4_flush", 1, 16'h0201, 16'h3C00);
      check("t4_done", done_cnt, 32'd1);

      // 31 zeros then a 1 is not a start frame; address wraps at the top
      clear_log();
      led_count = 16'd1; start_address = 16'hFFFF;
      send_bits(32'h0, 31);
      send_bit(1'b1);
      check("t5_busy_short_start", {31'h0, busy}, 32'h0);
      send_start();
      send_led(8'hE1, 24'hC0FFEE);
      send_end();
      check("t5_nwrites", wa_q.size(), 32'd2);
      check_write("t5_w0", 0, 16'hFFFF, 16'hC0FF);
      check_write("t5_wrap", 1, 16'h0000, 16'hEE00);
      check("t5_done", done_cnt, 32'd1);

      // Zero LEDs: frame completes with no writes
      clear_log();
      led_count = 16'd0; start_address = 16'h0500;
      send_start();
      send_end();
      check("t6_nwrites", wa_q.size(), 32'd0);
      check("t6_done", done_cnt, 32'd1);

      // Reset on the write_strobe cycle
      clear_log();
      led_count = 16'd1; start_address = 16'h0400;
      send_start();
      send_bits(32'hFF, 8);
      send_bits(32'h52E1, 15);
      apa_data_in  = 1'b1;
      apa_clock_in = 1'b0;
      repeat (4) @(posedge clk);
      apa_clock_in = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         found = write_strobe;
      end
      check("t7_strobe_seen", {31'h0, found}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("t7_strobe_after_rst", {31'h0, write_strobe}, 32'h0);
      check("t7_data_after_rst", {16'h0, write_data}, 32'h0);
      check("t7_addr_after_rst", {16'h0, write_address}, 32'h0);
      check("t7_busy_after_rst", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      clear_log();
      send_start();
      send_led(8'hFF, 24'h123456);
      send_end();
      check("t7_nwrites", wa_q.size(), 32'd2);
      check_write("t7_w0", 0, 16'h0400, 16'h1234);
      check_write("t7_flush", 1, 16'h0401, 16'h5600);
      check("t7_done", done_cnt, 32'd1);

      check("single_cycle_strobes", double_strobe, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apa102_in.md
Name: apa102_in

Overview:
- APA102 receiver: decodes an incoming two-wire stream (data plus clock) made of a start frame, LED frames and an end frame.
- Unpacks the BGR payload into 16-bit words and writes them to page memory through a single-cycle write strobe.
- Used for loopback test of the LED output path and for capturing pixel streams from an external controller.
- Packing is bit-for-bit the inverse of the LED output path: BGR bits MSB-first, continuous across LED frame boundaries, 16 bits per word.

Parameters:
- ADDRESS_BUS_WIDTH, 16, width of write_address.
- TIMEOUT_CYCLES, 4096, number of clk cycles with no apa_clock_in rising edge that aborts the current frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- apa_clock_in  in  1  asynchronous serial clock; each high and each low phase must last at least 3 clk cycles.
- apa_data_in  in  1  asynchronous serial data; stable around the apa_clock_in rising edge.
- led_count  in  16  number of LED frames per frame; sampled when the start frame completes; 0 is legal.
- start_address  in  16  address of the first word written in each frame.
- write_address  out  ADDRESS_BUS_WIDTH  address for the current write.
- write_data  out  16  word to write.
- write_strobe  out  1  one-cycle write pulse.
- frame_done_strobe  out  1  one-cycle pulse when a frame completes.
- header_error  out  1  sticky flag, cleared only by rst.
- busy  out  1  high in HEADER, PAYLOAD and END.

Behaviour:
- Reset values: all outputs 0; state HUNT; all counters and the shift register 0.
- Input sampling: apa_clock_in and apa_data_in each pass through a 2-FF synchroniser. A rising edge is sync_clk high with the previous sample low. On that cycle the synchronised data bit is the received bit. Edges that violate the minimum phase width are undefined.
- HUNT:
  - Counts consecutive 0 bits; a 1 bit resets the count.
  - When the count reaches 32: latch led_count into leds_left, set word_ptr = start_address, clear the bit/word packer.
  - If leds_left is 0, go to END; otherwise go to HEADER.
  - Extra zeros beyond 32 are legal; HEADER does not begin until the first 1 bit.
- HEADER:
  - Collects 8 bits.
  - Checks the top 3 bits (see Optional Feature), then goes to PAYLOAD with a 24-bit counter.
- PAYLOAD:
  - Each bit shifts into a 16-bit register, MSB first.
  - On the 16th bit the word is emitted. On the next clk: write_data = word, write_address = word_ptr, write_strobe = 1 for exactly one cycle. Then word_ptr increments, wrapping modulo 2^ADDRESS_BUS_WIDTH.
  - After 24 bits, decrement leds_left. If nonzero go to HEADER; otherwise, if the packer holds a partial word, go to END and flush it.
- Flush on entering END: write the partial word left-aligned with unused LSBs set to 0, using the same one-cycle write timing.
- END:
  - Counts consecutive 1 bits; a 0 bit resets the count.
  - When the count reaches 32: pulse frame_done_strobe the next clk and return to HUNT.
  - When led_count is 0, END is reached directly from HUNT and the frame completes with no writes.
- Timeout: in any state other than HUNT, TIMEOUT_CYCLES clk cycles without a rising edge return the block to HUNT.
  - A partially assembled word is discarded.
  - No frame_done_strobe and no error flag.
- Simultaneous events: a word emit and a state change on the same bit are both honoured; the write pulse is never dropped.
- Reset mid-frame: any pending write is cancelled, all outputs return to 0, and the block returns to HUNT.
- Write port has no backpressure; downstream must accept one write every 16 serial bits.

Optional Feature:
- Macro: APA102_IN_HEADER_CHECK_EN.
- Defined: if the top 3 header bits are not 111, set header_error, abort the frame without flush and return to HUNT. No frame_done_strobe.
- Undefined: headers are accepted unconditionally and header_error stays 0.

Decomposition:
- Shared package apa102_pkg:
  - state enum (HUNT, HEADER, PAYLOAD, END);
  - START_FRAME_BITS = 32, END_FRAME_BITS = 32, HEADER_BITS = 8, PIXEL_BITS = 24;
  - HEADER_MARKER = 3'b111.
- One sub-module: input_sync_edge (2-FF synchroniser plus rising-edge detect), instantiated for the clock and data lines.

Test Plan:
- led_count=2, start_address=0x0100, pixels BGR 0x123456 and 0x789ABC with header 0xFF -> 3 writes: 0x0100=0x1234, 0x0101=0x5678, 0x0102=0x9ABC; then one frame_done_strobe.
- led_count=1, pixel 0xA5C33C -> writes 0x0100=0xA5C3 and flush 0x0101=0x3C00; then frame_done_strobe.
- led_count=1 with header 0x5F:
  - macro defined -> header_error=1, no writes, no frame_done_strobe;
  - macro undefined -> normal write of the pixel and frame_done_strobe.
- Serial clock stops mid-PAYLOAD for TIMEOUT_CYCLES+1 cycles, then a valid led_count=1 frame is sent -> no write from the aborted frame; the next frame writes correctly from start_address.
- Start frame of 31 zeros, a 1, then a valid frame -> first attempt ignored; the valid frame decodes normally.
- rst asserted on the cycle of a write_strobe -> write_strobe=0 the next cycle; the next frame writes from start_address.
